glb_stream_loader: RTL and testbench

GLB_STREAM_LOADER -- requirements
Module: glb_stream_loader

---
 rtl/glb_stream_loader.sv | 147 ++++++++++++++
 tb/tb_glb_stream_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/glb_stream_loader.sv
// Streams source words into a global buffer region. Each word is tagged with a PE column id and a channel index.
// One job fills NUM_CH channels of len words each, starting at base_addr and wrapping at the buffer top.
module glb_stream_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_COL     = 10,
    parameter int NUM_CH      = 4,
    parameter int BUFFER_SIZE = 512,
    localparam int ADDR_W = $clog2(BUFFER_SIZE),
    localparam int ID_W   = $clog2(NUM_COL) + 1,
    localparam int CH_W   = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1,
    localparam int LEN_W  = ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            kernel_size,
    input  logic [LEN_W-1:0]      len,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  full,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ID_W-1:0]       wr_id,
    output logic [CH_W-1:0]       wr_ch,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [7:0]          kernel_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    widx;
    logic [7:0]          kcnt;
    logic [ID_W-1:0]     id;
    logic [CH_W-1:0]     ch;
    logic [ADDR_W-1:0]   ptr;
    logic [31:0]         job_words;
    logic                cfg_bad, start_ok, xfer;
    logic                last_word, last_ch, kcnt_last, id_last, ptr_last;

    // A word moves only on a rising edge where s_valid and s_ready are both high.
    // s_ready never depends on s_valid, so the source may hold s_valid high across any stall.
    assign xfer      = s_valid & s_ready;
    assign job_words = 32'(len) * 32'(NUM_CH);
    assign cfg_bad   = (kernel_size == 8'd0) || (len == '0) || (job_words > 32'(BUFFER_SIZE));
    assign start_ok  = (state_q == S_IDLE) && start && !cfg_bad;
    assign last_word = (widx == len_q - LEN_W'(1));
    assign last_ch   = (ch == CH_W'(NUM_CH - 1));
    assign kcnt_last = (kcnt == kernel_q - 8'd1);
    assign id_last   = (id == ID_W'(NUM_COL - 1));
    assign ptr_last  = (ptr == ADDR_W'(BUFFER_SIZE - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_LOAD;
            S_LOAD: begin
                if (abort)                           state_d = S_IDLE;
                else if (xfer && last_word && last_ch) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state_q == S_LOAD) && !full && !abort;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
    end

    // ptr walks the same sequence as base_addr + ch*len + widx, because widx restarts exactly when ch steps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            kernel_q <= '0;
            len_q    <= '0;
            ptr      <= '0;
            widx     <= '0;
            kcnt     <= '0;
            id       <= '0;
            ch       <= '0;
        end else if (start_ok) begin
            kernel_q <= kernel_size;
            len_q    <= len;
            ptr      <= base_addr;
            widx     <= '0;
            kcnt     <= '0;
            id       <= '0;
            ch       <= '0;
        end else if (state_q == S_LOAD && abort) begin
            ptr  <= '0;
            widx <= '0;
            kcnt <= '0;
            id   <= '0;
            ch   <= '0;
        end else if (xfer) begin
            ptr <= ptr_last ? '0 : ptr + ADDR_W'(1);
            if (last_word) begin
                widx <= '0;
                kcnt <= '0;
                id   <= '0;
                ch   <= last_ch ? '0 : ch + CH_W'(1);
            end else begin
                widx <= widx + LEN_W'(1);
                if (kcnt_last) begin
                    kcnt <= '0;
                    id   <= id_last ? '0 : id + ID_W'(1);
                end else begin
                    kcnt <= kcnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_id   <= '0;
            wr_ch   <= '0;
        end else begin
            if (state_q == S_IDLE && start) err <= cfg_bad;
            wr_en <= xfer;
            if (xfer) begin
                wr_addr <= ptr;
                wr_data <= s_data;
                wr_id   <= id;
                wr_ch   <= ch;
            end
        end
    end

endmodule

// File: tb/tb_glb_stream_loader.sv
// Scoreboard bench for glb_stream_loader (two channels, ten columns, 512-word buffer).
// Expected writes are queued when a job is issued; a negedge monitor pops and compares every wr_en.
module tb_glb_stream_loader;

  localparam int DW     = 16;
  localparam int NCOL   = 10;
  localparam int NCH    = 2;
  localparam int BUF    = 512;
  localparam int ADDR_W = 9;
  localparam int ID_W   = 5;
  localparam int CH_W   = 1;
  localparam int LEN_W  = 10;
  localparam int EW     = 1 + CH_W + ID_W + ADDR_W + DW;

  logic              clk, rstn, start, abort, s_valid, s_ready, full;
  logic [7:0]        kernel_size;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] base_addr;
  logic [DW-1:0]     s_data;
  logic              wr_en, busy, done, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [DW-1:0]     wr_data;
  logic [ID_W-1:0]   wr_id;
  logic [CH_W-1:0]   wr_ch;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  glb_stream_loader #(
    .DATA_WIDTH(DW), .NUM_COL(NCOL), .NUM_CH(NCH), .BUFFER_SIZE(BUF)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .kernel_size(kernel_size), .len(len), .base_addr(base_addr),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .full(full),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_id(wr_id),
    .wr_ch(wr_ch), .busy(busy), .done(done), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  // Model of one write: word n of a job with the given config.
  function automatic logic [EW-1:0] exp_word(input int n, input int ks, input int l,
                                             input int base, input int dbase, input int total);
    int c, w, i, a;
    logic dn;
    c  = n / l;
    w  = n % l;
    i  = (w / ks) % NCOL;
    a  = (base + n) % BUF;
    dn = (n == total - 1);
    return {dn, CH_W'(c), ID_W'(i), ADDR_W'(a), DW'(dbase + n)};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rstn) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {8'h0, done, wr_ch, wr_id, wr_addr, wr_data}, 32'hFFFF_FFFF);
        end else begin
          check("write", {done, wr_ch, wr_id, wr_addr, wr_data}, exp_q.pop_front());
        end
      end else if (done) begin
        check("done_without_write", 32'(done), 32'd0);
      end
    end
  end

  // driver tasks; all begin and end 1 time unit after a rising edge
  task automatic start_job(input int ks, input int l, input int base);
    kernel_size = 8'(ks);
    len         = LEN_W'(l);
    base_addr   = ADDR_W'(base);
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_words(input int total, input int stop_at, input int dbase, input bit bp,
                            input bit gaps, input bit junk, input int abort_at);
    int  n = 0;
    int  cyc = 0;
    bit  acc;
    while (n < stop_at && cyc < 5000) begin
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = DW'(dbase + n);
      full    = bp && (cyc % 3 == 2);
      abort   = (n == abort_at);
      start   = junk && (n < total - 1);
      if (junk) begin
        kernel_size = 8'd1;
        len         = LEN_W'(3);
        base_addr   = ADDR_W'(100);
      end
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
      if (abort) begin
        abort = 1'b0;
        break;
      end
      if (acc) n++;
    end
    if (cyc >= 5000) check("send_timeout", 32'(n), 32'(stop_at));
    s_valid = 1'b0;
    full    = 1'b0;
    start   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("leftover_writes", 32'(exp_q.size()), 32'd0);
    check("busy_after_job", 32'(busy), 32'd0);
  endtask

  task automatic run_job(input int ks, input int l, input int base, input int dbase,
                         input bit bp, input bit gaps, input bit junk,
                         input int abort_at, input bit abort_in_done);
    int total = l * NCH;
    int cnt   = (abort_at >= 0) ? abort_at : total;
    start_job(ks, l, base);
    check("busy_on_start", 32'(busy), 32'd1);
    check("err_on_start", 32'(err), 32'd0);
    for (int n = 0; n < cnt; n++) exp_q.push_back(exp_word(n, ks, l, base, dbase, total));
    send_words(total, total, dbase, bp, gaps, junk, abort_at);
    if (abort_at >= 0) check("busy_after_abort", 32'(busy), 32'd0);
    if (abort_in_done) begin
      check("in_done_state", 32'(done), 32'd1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    drain();
  endtask

  task automatic bad_start(input int ks, input int l);
    kernel_size = 8'(ks);
    len         = LEN_W'(l);
    base_addr   = '0;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_set", 32'(err), 32'd1);
    check("busy_after_bad", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("err_sticky", 32'(err), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_wr_en"},   32'(wr_en),   32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_wr_id"},   32'(wr_id),   32'd0);
    check({tag, "_wr_ch"},   32'(wr_ch),   32'd0);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_done"},    32'(done),    32'd0);
    check({tag, "_err"},     32'(err),     32'd0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; full = 1'b0;
    kernel_size = '0; len = '0; base_addr = '0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // basic: ks=5, len=12, base 0 -> addr 0..23, ids 0x5,1x5,2x2 per channel
    run_job(5, 12, 0, 16'h1000, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    // same job under back-pressure and source gaps, with start held during the job
    run_job(5, 12, 0, 16'h2000, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    // address wrap: base 510 -> 510,511,0,1,...
    run_job(2, 4, 510, 16'h3000, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    // id wrap: ks=1 -> ids 0..9,0,1; abort held in DONE must not stop the done pulse
    run_job(1, 12, 0, 16'h4000, 1'b0, 1'b1, 1'b0, -1, 1'b1);

    // configuration errors
    bad_start(0, 12);
    bad_start(5, 300);
    bad_start(5, 0);
    bad_start(5, 257);
    // largest legal job (exactly fills the buffer) clears err
    run_job(3, 256, 7, 16'h5000, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    // abort after 7 transfers
    run_job(5, 12, 0, 16'h6000, 1'b0, 1'b0, 1'b0, 7, 1'b0);

    // reset mid-job, then the basic job again
    start_job(5, 12, 0);
    for (int n = 0; n < 24; n++) exp_q.push_back(exp_word(n, 5, 12, 0, 16'h7000, 24));
    send_words(24, 6, 16'h7000, 1'b0, 1'b0, 1'b0, -1);
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_job(5, 12, 0, 16'h8000, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
